// File: rtl/config_frame_writer_pkg.sv
// ---------------------------------------------------------------------------
// config_frame_writer_pkg
// Shared definitions for the configuration frame writer:
//   state_t        - writer FSM states
//   CMD_* consts   - bit positions of fields inside a command word
//   COL_WIDTH      - width of the column address field
//   IDX_WIDTH      - width of the frame index field
//   idx_in_range() - true when a frame index addresses an existing frame
// ---------------------------------------------------------------------------
package config_frame_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } state_t;

    localparam int CMD_FLAG_BIT = 31;
    localparam int CMD_COL_HI   = 30;
    localparam int CMD_COL_LO   = 24;
    localparam int CMD_IDX_HI   = 4;
    localparam int CMD_IDX_LO   = 0;

    localparam int COL_WIDTH = CMD_COL_HI - CMD_COL_LO + 1;
    localparam int IDX_WIDTH = CMD_IDX_HI - CMD_IDX_LO + 1;

    function automatic logic idx_in_range(input logic [IDX_WIDTH-1:0] idx,
                                          input int maxFrames);
        return int'(idx) < maxFrames;
    endfunction

endpackage

// File: rtl/config_frame_writer_strobe_decoder.sv
// ---------------------------------------------------------------------------
// config_strobe_decoder
// Turns a frame index into a one-hot frame latch enable vector.
// Ports:
//   i_idx    - frame index taken from the command word
//   i_en     - when low the output vector is all zero
//   o_strobe - one-hot enable, MaxFramesPerCol bits; all zero when the index
//              does not address an existing frame
// ---------------------------------------------------------------------------
module config_strobe_decoder
    import config_frame_writer_pkg::*;
#(
    parameter int MaxFramesPerCol = 20
) (
    input  logic [IDX_WIDTH-1:0]       i_idx,
    input  logic                       i_en,
    output logic [MaxFramesPerCol-1:0] o_strobe
);

    // Indices beyond the last frame match no bit, so out-of-range
    // requests naturally decode to an all-zero vector.
    always_comb begin
        o_strobe = '0;
        for (int i = 0; i < MaxFramesPerCol; i++) begin
            if (i_en && (int'(i_idx) == i)) begin
                o_strobe[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/config_frame_writer.sv
// ---------------------------------------------------------------------------
// config_frame_writer
// Accepts a command word (column + frame index) followed by a data word and
// writes the data into one configuration frame of the addressed tile column:
// FrameData is set up for one cycle, the selected FrameStrobe bit is held for
// StrobeWidth cycles, FrameData is held one more cycle, then frame_done pulses.
// Ports:
//   CLK         - clock, rising edge
//   resetn      - synchronous active-low reset
//   in_word     - command or data word
//   in_valid    - in_word valid
//   in_ready    - writer accepts in_word this cycle (IDLE and DATA only)
//   FrameData   - frame contents to the column configuration memories
//   FrameStrobe - one-hot frame latch enable
//   frame_done  - one-cycle pulse after a completed frame write
//   frame_err   - sticky out-of-range frame index error
// Build option:
//   FRAME_RANGE_CHECK_EN - when defined, an out-of-range index on this column
//                          sets frame_err until reset; otherwise frame_err is
//                          tied low and such frames are dropped silently.
// ---------------------------------------------------------------------------
module config_frame_writer
    import config_frame_writer_pkg::*;
#(
    parameter int                   MaxFramesPerCol = 20,
    parameter int                   FrameBitsPerRow = 32,
    parameter logic [COL_WIDTH-1:0] ColumnId        = '0,
    parameter int                   StrobeWidth     = 1
) (
    input  logic                       CLK,
    input  logic                       resetn,
    input  logic [FrameBitsPerRow-1:0] in_word,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       frame_done,
    output logic                       frame_err
);

    state_t                     r_state;
    state_t                     w_nextState;
    logic [COL_WIDTH-1:0]       r_col;
    logic [IDX_WIDTH-1:0]       r_idx;
    logic [FrameBitsPerRow-1:0] r_frameData;
    logic [MaxFramesPerCol-1:0] r_frameStrobe;
    logic [MaxFramesPerCol-1:0] w_strobeNext;
    logic                       r_frameDone;
    logic [3:0]                 r_strobeCnt;
    logic                       w_xfer;
    logic                       w_colMatch;
    logic                       w_inRange;
    logic                       w_hit;
    logic                       w_strobeLast;

    // in_ready is gated by resetn so nothing is accepted while reset is held.
    assign in_ready     = resetn && ((r_state == ST_IDLE) || (r_state == ST_DATA));
    assign w_xfer       = in_valid && in_ready;
    assign w_colMatch   = (r_col == ColumnId);
    assign w_inRange    = idx_in_range(r_idx, MaxFramesPerCol);
    assign w_hit        = w_colMatch && w_inRange;
    assign w_strobeLast = (r_strobeCnt == 4'(StrobeWidth - 1));

    // Next-state logic. Frames for another column or with a bad index still
    // pass through SETUP and HOLD but never enter STROBE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:   if (w_xfer && in_word[CMD_FLAG_BIT]) w_nextState = ST_DATA;
            ST_DATA:   if (w_xfer) w_nextState = ST_SETUP;
            ST_SETUP:  w_nextState = w_hit ? ST_STROBE : ST_HOLD;
            ST_STROBE: if (w_strobeLast) w_nextState = ST_HOLD;
            ST_HOLD:   w_nextState = ST_IDLE;
            default:   w_nextState = ST_IDLE;
        endcase
    end

    // Decoding against the next state lets the strobe come straight out of a
    // flop and line up exactly with the STROBE state.
    config_strobe_decoder #(
        .MaxFramesPerCol(MaxFramesPerCol)
    ) u_decoder (
        .i_idx    (r_idx),
        .i_en     (w_nextState == ST_STROBE),
        .o_strobe (w_strobeNext)
    );

    // Main datapath and state registers. FrameData only loads on the
    // data-word transfer; frame_done is registered so it follows HOLD.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_col         <= '0;
            r_idx         <= '0;
            r_frameData   <= '0;
            r_frameStrobe <= '0;
            r_frameDone   <= 1'b0;
            r_strobeCnt   <= '0;
        end else begin
            r_state <= w_nextState;
            if ((r_state == ST_IDLE) && w_xfer && in_word[CMD_FLAG_BIT]) begin
                r_col <= in_word[CMD_COL_HI:CMD_COL_LO];
                r_idx <= in_word[CMD_IDX_HI:CMD_IDX_LO];
            end
            if ((r_state == ST_DATA) && w_xfer) begin
                r_frameData <= in_word;
            end
            r_frameStrobe <= w_strobeNext;
            r_frameDone   <= (r_state == ST_HOLD) && w_hit;
            r_strobeCnt   <= (r_state == ST_STROBE) ? r_strobeCnt + 4'd1 : 4'd0;
        end
    end

`ifdef FRAME_RANGE_CHECK_EN
    logic r_frameErr;

    // Sticky flag: a bad index on our own column is remembered until reset.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            r_frameErr <= 1'b0;
        end else if ((r_state == ST_SETUP) && w_colMatch && !w_inRange) begin
            r_frameErr <= 1'b1;
        end
    end

    assign frame_err = r_frameErr;
`else
    assign frame_err = 1'b0;
`endif

    assign FrameData   = r_frameData;
    assign FrameStrobe = r_frameStrobe;
    assign frame_done  = r_frameDone;

endmodule

// File: doc/config_frame_writer.md
CONFIG_FRAME_WRITER -- requirements
Module: config_frame_writer

Interface
REQ-001 SHALL have parameter MaxFramesPerCol, default 20: number of frame strobes driven into one tile column.
REQ-002 SHALL have parameter FrameBitsPerRow, default 32: width of FrameData and of the input word.
REQ-003 SHALL have parameter ColumnId, default 0, 7 bits: column address this writer answers to.
REQ-004 SHALL have parameter StrobeWidth, default 1, range 1..15: cycles FrameStrobe is held high.
REQ-005 SHALL have port CLK, input, 1: the only clock; all logic on its rising edge.
REQ-006 SHALL have port resetn, input, 1: synchronous, active-low reset.
REQ-007 SHALL have port in_word, input, FrameBitsPerRow: command or data word.
REQ-008 SHALL have port in_valid, input, 1: in_word valid.
REQ-009 SHALL have port in_ready, output, 1: writer accepts in_word this cycle.
REQ-010 SHALL have port FrameData, output, FrameBitsPerRow: frame contents to the column config memories.
REQ-011 SHALL have port FrameStrobe, output, MaxFramesPerCol: one-hot frame latch enable.
REQ-012 SHALL have port frame_done, output, 1: one-cycle pulse when a frame write completes.
REQ-013 SHALL have port frame_err, output, 1: sticky out-of-range error (see Configuration).

Function
REQ-014 Transfer SHALL occur on a cycle with in_valid and in_ready both high; in_word SHALL be ignored otherwise.
REQ-015 Command word layout SHALL be: bit 31 = 1, bits 30:24 = column, bits 4:0 = frame index; other bits ignored.
REQ-016 States SHALL be IDLE, DATA, SETUP, STROBE, HOLD; in_ready SHALL be high only in IDLE and DATA.
REQ-017 IDLE: a word with bit 31 = 1 SHALL be latched as command and move to DATA; a word with bit 31 = 0 SHALL be consumed and discarded.
REQ-018 DATA: the next accepted word SHALL be loaded into FrameData and move to SETUP, regardless of its bit 31.
REQ-019 SETUP SHALL last exactly 1 cycle with FrameData stable and FrameStrobe all zero.
REQ-020 STROBE SHALL drive FrameStrobe bit [frame index] high for exactly StrobeWidth cycles; all other bits low.
REQ-021 HOLD SHALL last 1 cycle with FrameStrobe zero and FrameData unchanged, then pulse frame_done and return to IDLE.
REQ-022 Column mismatch SHALL still consume the data word but skip STROBE, and SHALL NOT pulse frame_done or set frame_err.
REQ-023 Frame index >= MaxFramesPerCol SHALL consume the data word and produce no strobe.
REQ-024 FrameData SHALL change only on the DATA-state transfer.
REQ-025 Minimum per-frame latency SHALL be 2 + 1 + StrobeWidth + 1 cycles from command transfer to frame_done.

Reset
REQ-026 resetn low SHALL, on the next edge, force IDLE, FrameData = 0, FrameStrobe = 0, frame_done = 0, frame_err = 0, and discard any latched command.
REQ-027 in_ready SHALL be 0 while resetn is low and 1 on the first cycle after release.
REQ-028 Reset asserted during STROBE SHALL clear FrameStrobe on the same edge; no partial frame resumes.

Configuration
REQ-029 Macro FRAME_RANGE_CHECK_EN defined: an out-of-range index on a matching column SHALL set frame_err, which stays high until reset.
REQ-030 Macro FRAME_RANGE_CHECK_EN undefined: frame_err SHALL be tied 0 and the frame SHALL be dropped silently.

Structure
REQ-031 A shared package SHALL hold the state enum, command-bit positions (CMD_FLAG_BIT, CMD_COL_HI/LO, CMD_IDX_HI/LO) and the 7-bit column width constant.
REQ-032 One sub-module, config_strobe_decoder (index plus enable in, one-hot MaxFramesPerCol vector out, zero when index is out of range), SHALL be instantiated.

Verification
REQ-033 ColumnId=3: command 0x8300_0005, then 0xDEADBEEF -> SETUP cycle with FrameData=0xDEADBEEF; FrameStrobe=0x00020 for 1 cycle; frame_done 1 cycle after that.
REQ-034 Command 0x8400_0005 with ColumnId=3, then data -> FrameData updates, FrameStrobe stays 0, no frame_done.
REQ-035 Index 25 with MaxFramesPerCol=20 -> no strobe; frame_err=1 with the macro and 0 without.
REQ-036 StrobeWidth=4, back-to-back frames with in_valid always high -> strobe high 4 cycles, in_ready low 6 cycles per frame, FrameData stable around each strobe.
REQ-037 resetn low during STROBE -> next edge FrameStrobe=0, FrameData=0; a data word 0x12345678 before any command -> discarded, no strobe.
